// File: rtl/writeback_multi.sv
// writeback_multi -- multi-lane MEM/WB pipeline register and register-file writeback.
//
// Holds one bundle of LANES instructions (lane 0 oldest). From the stored bundle
// it derives one register-file write per lane:
//   - Branch-and-link rewrites the write to LINK_REG with pc + LINK_OFFSET.
//   - Writes to register 0 are suppressed.
//   - When lanes in the same bundle write the same register, only the youngest
//     enabled one is kept.
// A retire counter accumulates the number of valid lanes each time the bundle
// leaves WB.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous reset, active high
//   stall           hold WB contents
//   flush           drop the incoming bundle; WB becomes empty
//   in_valid        [LANES]          per-lane instruction valid
//   in_result       [LANES*DATA_W]   per-lane result, lane i at [i*DATA_W +: DATA_W]
//   in_pc           [LANES*ADDR_W]   per-lane PC
//   in_dest         [LANES*5]        per-lane destination register
//   in_write_en     [LANES]          per-lane register write request
//   in_branch_link  [LANES]          per-lane link request
//   reg_write_en    [LANES]          per-lane register-file write enable
//   reg_write_dest  [LANES*5]        per-lane write register
//   reg_write_data  [LANES*DATA_W]   per-lane write data
//   retire_valid    [LANES]          lanes holding a valid instruction in WB
//   retire_count    [CNT_W]          running count of retired instructions
//
// All outputs are driven from the WB register only.

module writeback_multi #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int LINK_REG    = 31,
  parameter int LINK_OFFSET = 8,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_result,
  input  logic [LANES*ADDR_W-1:0] in_pc,
  input  logic [LANES*5-1:0]      in_dest,
  input  logic [LANES-1:0]        in_write_en,
  input  logic [LANES-1:0]        in_branch_link,
  output logic [LANES-1:0]        reg_write_en,
  output logic [LANES*5-1:0]      reg_write_dest,
  output logic [LANES*DATA_W-1:0] reg_write_data,
  output logic [LANES-1:0]        retire_valid,
  output logic [CNT_W-1:0]        retire_count
);

  // Link address is formed at the wider of the two widths so that a DATA_W
  // wider than ADDR_W keeps the carry out of the PC add.
  localparam int SUM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  logic [LANES-1:0]        valid_q,  valid_d;
  logic [LANES-1:0]        wr_q,     wr_d;
  logic [LANES-1:0]        link_q,   link_d;
  logic [LANES*DATA_W-1:0] result_q, result_d;
  logic [LANES*ADDR_W-1:0] pc_q,     pc_d;
  logic [LANES*5-1:0]      dest_q,   dest_d;
  logic [CNT_W-1:0]        count_q,  count_d;

  logic [CNT_W-1:0]        valid_pop;
  logic                    advance;

  // The bundle in WB leaves (and is counted) whenever the register is replaced,
  // including on flush: flush only discards the incoming bundle.
  assign advance = flush | ~stall;

  // ---------------------------------------------------------------------------
  // WB register next state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    wr_d     = wr_q;
    link_d   = link_q;
    result_d = result_q;
    pc_d     = pc_q;
    dest_d   = dest_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d  = in_valid;
      wr_d     = in_write_en;
      link_d   = in_branch_link;
      result_d = in_result;
      pc_d     = in_pc;
      dest_d   = in_dest;
    end
  end

  always_comb begin
    valid_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      valid_pop = valid_pop + CNT_W'(valid_q[i]);
    end
  end

  assign count_d = advance ? (count_q + valid_pop) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_q     <= '0;
      link_q   <= '0;
      result_q <= '0;
      pc_q     <= '0;
      dest_q   <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_q     <= wr_d;
      link_q   <= link_d;
      result_q <= result_d;
      pc_q     <= pc_d;
      dest_q   <= dest_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Effective per-lane write (link overrides the stored write fields)
  // ---------------------------------------------------------------------------
  logic [4:0]        eff_dest [LANES];
  logic [DATA_W-1:0] eff_data [LANES];
  logic              eff_wr   [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SUM_W-1:0] link_sum;

    assign link_sum    = SUM_W'(pc_q[g*ADDR_W +: ADDR_W]) + SUM_W'(LINK_OFFSET);
    assign eff_dest[g] = link_q[g] ? 5'(LINK_REG) : dest_q[g*5 +: 5];
    assign eff_data[g] = link_q[g] ? DATA_W'(link_sum) : result_q[g*DATA_W +: DATA_W];
    assign eff_wr[g]   = link_q[g] | wr_q[g];
  end

  // A lane is killed when any younger valid writing lane targets the same
  // register, so the last write in program order is the one that lands.
  logic [LANES-1:0] killed;

  always_comb begin
    killed = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (valid_q[j] && eff_wr[j] && (eff_dest[j] == eff_dest[i])) begin
          killed[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_write_en   = '0;
    reg_write_dest = '0;
    reg_write_data = '0;
    for (int i = 0; i < LANES; i++) begin
      reg_write_en[i] = valid_q[i] & eff_wr[i] & (eff_dest[i] != 5'd0) & ~killed[i];
      reg_write_dest[i*5 +: 5]           = eff_dest[i];
      reg_write_data[i*DATA_W +: DATA_W] = eff_data[i];
    end
  end

  assign retire_valid = valid_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_writeback_multi.sv
module tb_writeback_multi;

  localparam int L  = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst, stall, flush;
  logic [L-1:0]    in_valid, in_write_en, in_branch_link;
  logic [L*DW-1:0] in_result;
  logic [L*AW-1:0] in_pc;
  logic [L*5-1:0]  in_dest;

  logic [L-1:0]    reg_write_en, retire_valid;
  logic [L*5-1:0]  reg_write_dest;
  logic [L*DW-1:0] reg_write_data;
  logic [31:0]     retire_count;

  logic [L-1:0]    s_en, s_rv;
  logic [L*5-1:0]  s_dest;
  logic [L*DW-1:0] s_data;
  logic [3:0]      s_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  writeback_multi #(.LANES(L), .DATA_W(DW), .ADDR_W(AW), .LINK_REG(31),
                    .LINK_OFFSET(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_result(in_result), .in_pc(in_pc), .in_dest(in_dest),
    .in_write_en(in_write_en), .in_branch_link(in_branch_link),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .retire_valid(retire_valid),
    .retire_count(retire_count)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap behaviour.
  writeback_multi #(.LANES(L), .DATA_W(DW), .ADDR_W(AW), .LINK_REG(31),
                    .LINK_OFFSET(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_result(in_result), .in_pc(in_pc), .in_dest(in_dest),
    .in_write_en(in_write_en), .in_branch_link(in_branch_link),
    .reg_write_en(s_en), .reg_write_dest(s_dest),
    .reg_write_data(s_data), .retire_valid(s_rv),
    .retire_count(s_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the bundle sitting in WB plus a retire total.
  // ---------------------------------------------------------------------------
  logic        m_v   [L];
  logic [31:0] m_res [L];
  logic [31:0] m_pc  [L];
  logic [4:0]  m_dst [L];
  logic        m_wr  [L];
  logic        m_lk  [L];
  logic [31:0] m_cnt;

  function automatic logic [31:0] m_pop();
    logic [31:0] p;
    p = 0;
    for (int i = 0; i < L; i++) p = p + (m_v[i] ? 32'd1 : 32'd0);
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 32'd0;
      for (int i = 0; i < L; i++) begin
        m_v[i] <= 1'b0; m_res[i] <= '0; m_pc[i] <= '0;
        m_dst[i] <= '0; m_wr[i] <= 1'b0; m_lk[i] <= 1'b0;
      end
    end else begin
      if (flush || !stall) m_cnt <= m_cnt + m_pop();
      if (flush) begin
        for (int i = 0; i < L; i++) m_v[i] <= 1'b0;
      end else if (!stall) begin
        for (int i = 0; i < L; i++) begin
          m_v[i]   <= in_valid[i];
          m_res[i] <= in_result[i*DW +: DW];
          m_pc[i]  <= in_pc[i*AW +: AW];
          m_dst[i] <= in_dest[i*5 +: 5];
          m_wr[i]  <= in_write_en[i];
          m_lk[i]  <= in_branch_link[i];
        end
      end
    end
  end

  // What the register file must see for the bundle currently in the model.
  task automatic model_out(output logic [L-1:0] en, output logic [L*5-1:0] dst,
                           output logic [L*DW-1:0] dat);
    logic [4:0]  d [L];
    logic        w [L];
    logic        younger_hit;
    en = '0; dst = '0; dat = '0;
    for (int i = 0; i < L; i++) begin
      d[i] = m_lk[i] ? 5'd31 : m_dst[i];
      w[i] = m_lk[i] | m_wr[i];
      dst[i*5 +: 5]   = d[i];
      dat[i*DW +: DW] = m_lk[i] ? (m_pc[i] + 32'd8) : m_res[i];
    end
    for (int i = 0; i < L; i++) begin
      younger_hit = 1'b0;
      for (int j = i + 1; j < L; j++)
        if (m_v[j] && w[j] && d[j] == d[i]) younger_hit = 1'b1;
      en[i] = m_v[i] && w[i] && (d[i] != 5'd0) && !younger_hit;
    end
  endtask

  always @(negedge clk) begin
    logic [L-1:0]    e_en;
    logic [L*5-1:0]  e_dst;
    logic [L*DW-1:0] e_dat;
    if (chk_on) begin
      model_out(e_en, e_dst, e_dat);
      chk("en",     {62'd0, reg_write_en},   {62'd0, e_en});
      chk("dest",   {54'd0, reg_write_dest}, {54'd0, e_dst});
      chk("data",   reg_write_data,          e_dat);
      chk("rvalid", {62'd0, retire_valid},   {62'd0, m_v[1], m_v[0]});
      chk("count",  {32'd0, retire_count},   {32'd0, m_cnt});
      chk("count4", {60'd0, s_count},        {60'd0, m_cnt[3:0]});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change just after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0; in_write_en = '0; in_branch_link = '0;
    in_result = '0; in_pc = '0; in_dest = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [31:0] res,
                          input logic [31:0] pc, input logic [4:0] d,
                          input bit w, input bit lk);
    in_valid[i]           = v;
    in_result[i*DW +: DW] = res;
    in_pc[i*AW +: AW]     = pc;
    in_dest[i*5 +: 5]     = d;
    in_write_en[i]        = w;
    in_branch_link[i]     = lk;
  endtask

  task automatic full_bundle();
    set_lane(0, 1, 32'h0000_1111, 32'h100, 5'd1, 1, 0);
    set_lane(1, 1, 32'h0000_2222, 32'h104, 5'd2, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    chk_on = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("reset_en", {62'd0, reg_write_en}, 64'd0);
    chk("reset_cnt", {32'd0, retire_count}, 64'd0);

    // Single write on lane 0
    set_lane(0, 1, 32'hDEAD_BEEF, 32'h0, 5'd5, 1, 0);
    cyc();
    chk("single_en", {62'd0, reg_write_en}, 64'd1);
    chk("single_dest", {59'd0, reg_write_dest[4:0]}, 64'd5);
    chk("single_data", {32'd0, reg_write_data[31:0]}, 64'hDEAD_BEEF);
    idle();
    cyc();
    chk("single_cnt", {32'd0, retire_count}, 64'd1);

    // Link on lane 1, then link with PC wrap on lane 0 (link beats write_en)
    set_lane(1, 1, 32'h0, 32'hBFC0_0010, 5'd0, 0, 1);
    cyc();
    chk("link_en", {62'd0, reg_write_en}, 64'd2);
    chk("link_dest", {59'd0, reg_write_dest[9:5]}, 64'd31);
    chk("link_data", {32'd0, reg_write_data[63:32]}, 64'hBFC0_0018);
    idle();
    set_lane(0, 1, 32'h55, 32'hFFFF_FFFC, 5'd3, 1, 1);
    cyc();
    chk("wrap_en0", {63'd0, reg_write_en[0]}, 64'd1);
    chk("wrap_dest", {59'd0, reg_write_dest[4:0]}, 64'd31);
    chk("wrap_data", {32'd0, reg_write_data[31:0]}, 64'h4);

    // Collision: the younger lane wins; then a write to $0
    idle();
    set_lane(0, 1, 32'hAAAA_AAAA, 32'h0, 5'd7, 1, 0);
    set_lane(1, 1, 32'hBBBB_BBBB, 32'h0, 5'd7, 1, 0);
    cyc();
    chk("coll_en", {62'd0, reg_write_en}, 64'd2);
    chk("coll_data", {32'd0, reg_write_data[63:32]}, 64'hBBBB_BBBB);
    idle();
    set_lane(0, 1, 32'h1234, 32'h0, 5'd0, 1, 0);
    cyc();
    chk("zero_en", {62'd0, reg_write_en}, 64'd0);

    // Stall holds, flush under stall empties WB and retires the held bundle
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    full_bundle();
    cyc();
    chk("load_en", {62'd0, reg_write_en}, 64'd3);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1, $urandom, $urandom, 5'($urandom), 1, 0);
      set_lane(1, 0, $urandom, $urandom, 5'($urandom), 1, 0);
      cyc();
      chk("stall_en", {62'd0, reg_write_en}, 64'd3);
      chk("stall_data", {32'd0, reg_write_data[31:0]}, 64'h1111);
      chk("stall_cnt", {32'd0, retire_count}, 64'd0);
    end
    flush = 1'b1;
    cyc();
    chk("flush_rv", {62'd0, retire_valid}, 64'd0);
    chk("flush_cnt", {32'd0, retire_count}, 64'd2);
    idle();
    full_bundle();
    cyc();
    stall = 1'b1;
    rst = 1'b1;
    cyc();
    chk("rststall_rv", {62'd0, retire_valid}, 64'd0);
    chk("rststall_cnt", {32'd0, retire_count}, 64'd0);
    rst = 1'b0;

    // Full throughput for 10 bundles
    idle();
    for (int k = 0; k < 10; k++) begin
      full_bundle();
      cyc();
    end
    idle();
    cyc();
    chk("thru_cnt", {32'd0, retire_count}, 64'd20);
    chk("thru_cnt4", {60'd0, s_count}, 64'd4);

    // Randomised traffic; small destination range to provoke collisions
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < L; i++) begin
        set_lane(i, ($urandom_range(0, 3) != 0), $urandom,
                 (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0));
      end
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
